// File: rtl/instruction_fetch_controller_pkg.sv
// Shared types and constants for the instruction fetch controller slice:
// FSM state encoding, line geometry and PC field helpers.
package instruction_fetch_controller_pkg;

  localparam int INST_W      = 32;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_ADDR_W = 6;
  localparam int LINE_W      = INST_W * LINE_WORDS;
  localparam int WORD_SEL_W  = $clog2(LINE_WORDS);

  typedef enum logic [1:0] {
    FETCH     = 2'b00,
    MISS_REQ  = 2'b01,
    MISS_WAIT = 2'b10
  } fetch_state_t;

  // Line address of a PC; bits above the 1 KiB window are deliberately dropped,
  // so PCs 1 KiB apart alias onto the same line.
  function automatic logic [LINE_ADDR_W-1:0] line_addr_of(input logic [INST_W-1:0] pc);
    return pc[9:4];
  endfunction

  // Word index of a PC inside its 16-byte line.
  function automatic logic [WORD_SEL_W-1:0] word_index_of(input logic [INST_W-1:0] pc);
    return pc[3:2];
  endfunction

  // Pick word 'sel' out of a line; word k lives at bits [32k+31:32k].
  function automatic logic [INST_W-1:0] select_word(input logic [LINE_W-1:0] line,
                                                    input logic [WORD_SEL_W-1:0] sel);
    logic [INST_W-1:0] word;
    word = line[INST_W-1:0];
    for (int k = 0; k < LINE_WORDS; k++) begin
      if (sel == WORD_SEL_W'(k)) begin
        word = line[k*INST_W +: INST_W];
      end
    end
    return word;
  endfunction

endpackage

// File: rtl/instruction_fetch_controller_line_buffer.sv
// Single-line instruction buffer: holds one 128-bit line with its tag and
// valid bit, reports a hit for the looked-up line and selects the word.
module fetch_line_buffer
  import instruction_fetch_controller_pkg::*;
(
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   fill_en,
  input  logic [LINE_ADDR_W-1:0] fill_tag,
  input  logic [LINE_W-1:0]      fill_line,
  input  logic [LINE_ADDR_W-1:0] lookup_tag,
  input  logic [WORD_SEL_W-1:0]  lookup_word,
  output logic                   hit,
  output logic [INST_W-1:0]      hit_word
);

  logic                   line_valid;
  logic [LINE_ADDR_W-1:0] line_tag;
  logic [LINE_W-1:0]      line_data;

  // Capture a returned line together with its tag; reset invalidates and clears it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      line_valid <= 1'b0;
      line_tag   <= '0;
      line_data  <= '0;
    end else if (fill_en) begin
      line_valid <= 1'b1;
      line_tag   <= fill_tag;
      line_data  <= fill_line;
    end
  end

  // Tag compare and word select for the current PC.
  always_comb begin
    hit      = line_valid && (line_tag == lookup_tag);
    hit_word = select_word(line_data, lookup_word);
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: keeps the PC, serves instructions from a
// one-line buffer and refills it from a 128-bit memory on a miss.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          MISS_CNT_W = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   STALL,
  input  logic                   REDIRECT,
  input  logic [31:0]            REDIRECT_PC,
  output logic [31:0]            INSTRUCTION,
  output logic [31:0]            INST_PC,
  output logic                   INST_VALID,
  output logic                   MEM_READ,
  output logic [5:0]             MEM_ADDRESS,
  input  logic [127:0]           MEM_READINST,
  input  logic                   MEM_BUSYWAIT,
  output logic [MISS_CNT_W-1:0]  MISS_COUNT
);

  fetch_state_t          state;
  logic [31:0]           pc;
  logic                  buf_hit;
  logic [INST_W-1:0]     buf_word;
  logic                  fill_en;
  logic [31:0]           redirect_target;
  logic [MISS_CNT_W-1:0] miss_count_next;
  logic                  redirect_pc_unused;

  fetch_line_buffer u_line_buffer (
    .CLK         (CLK),
    .RESET       (RESET),
    .fill_en     (fill_en),
    .fill_tag    (MEM_ADDRESS),
    .fill_line   (MEM_READINST),
    .lookup_tag  (line_addr_of(pc)),
    .lookup_word (word_index_of(pc)),
    .hit         (buf_hit),
    .hit_word    (buf_word)
  );

  // Fill strobe, word-aligned redirect target and saturating miss-count increment.
  always_comb begin
    fill_en            = (state == MISS_WAIT) && !MEM_BUSYWAIT;
    redirect_target    = {REDIRECT_PC[31:2], 2'b00};
    redirect_pc_unused = ^REDIRECT_PC[1:0];
    miss_count_next    = (&MISS_COUNT) ? MISS_COUNT : MISS_COUNT + MISS_CNT_W'(1);
  end

  // Fetch FSM: PC, registered instruction outputs, memory request and miss counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      INSTRUCTION <= '0;
      INST_PC     <= '0;
      INST_VALID  <= 1'b0;
      MEM_READ    <= 1'b0;
      MEM_ADDRESS <= '0;
      MISS_COUNT  <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (REDIRECT) begin
            pc         <= redirect_target;
            INST_VALID <= 1'b0;
          end else if (STALL) begin
            state <= FETCH;
          end else if (buf_hit) begin
            INSTRUCTION <= buf_word;
            INST_PC     <= pc;
            INST_VALID  <= 1'b1;
            pc          <= pc + 32'd4;
          end else begin
            MEM_READ    <= 1'b1;
            MEM_ADDRESS <= line_addr_of(pc);
            MISS_COUNT  <= miss_count_next;
            INST_VALID  <= 1'b0;
            state       <= MISS_REQ;
          end
        end
        MISS_REQ: begin
          if (MEM_BUSYWAIT) begin
            state <= MISS_WAIT;
          end
          if (REDIRECT) begin
            pc         <= redirect_target;
            INST_VALID <= 1'b0;
          end else if (!STALL) begin
            INST_VALID <= 1'b0;
          end
        end
        MISS_WAIT: begin
          if (!MEM_BUSYWAIT) begin
            MEM_READ <= 1'b0;
            state    <= FETCH;
          end
          if (REDIRECT) begin
            pc         <= redirect_target;
            INST_VALID <= 1'b0;
          end else if (!STALL) begin
            INST_VALID <= 1'b0;
          end
        end
        default: begin
          state    <= FETCH;
          MEM_READ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller with a 3-cycle busywait
// memory model; miss counter is narrowed so saturation is reachable.
module tb_instruction_fetch_controller;

  logic         CLK;
  logic         RESET;
  logic         STALL;
  logic         REDIRECT;
  logic [31:0]  REDIRECT_PC;
  logic [31:0]  INSTRUCTION;
  logic [31:0]  INST_PC;
  logic         INST_VALID;
  logic         MEM_READ;
  logic [5:0]   MEM_ADDRESS;
  logic [127:0] MEM_READINST;
  logic         MEM_BUSYWAIT;
  logic [1:0]   MISS_COUNT;

  int vectors;
  int miscompares;
  int memCnt;
  logic sawReadLow;

  instruction_fetch_controller #(
    .RESET_PC   (32'h0000_0000),
    .MISS_CNT_W (2)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .STALL        (STALL),
    .REDIRECT     (REDIRECT),
    .REDIRECT_PC  (REDIRECT_PC),
    .INSTRUCTION  (INSTRUCTION),
    .INST_PC      (INST_PC),
    .INST_VALID   (INST_VALID),
    .MEM_READ     (MEM_READ),
    .MEM_ADDRESS  (MEM_ADDRESS),
    .MEM_READINST (MEM_READINST),
    .MEM_BUSYWAIT (MEM_BUSYWAIT),
    .MISS_COUNT   (MISS_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory contents: word at byte address a holds (a/4)+1, indexed by line address only.
  function automatic logic [127:0] memLine(input logic [5:0] lineAddr);
    logic [127:0] line;
    for (int k = 0; k < 4; k++) begin
      line[32*k +: 32] = 32'(lineAddr) * 32'd4 + 32'(k) + 32'd1;
    end
    return line;
  endfunction

  // Memory model: busywait rises the negedge after a request and stays high 3 cycles.
  initial begin
    MEM_BUSYWAIT = 1'b0;
    MEM_READINST = '0;
    memCnt = 0;
    forever begin
      @(negedge CLK);
      if (memCnt > 0) begin
        memCnt = memCnt - 1;
        if (memCnt == 0) MEM_BUSYWAIT = 1'b0;
      end else if (MEM_READ && !MEM_BUSYWAIT) begin
        MEM_BUSYWAIT = 1'b1;
        MEM_READINST = memLine(MEM_ADDRESS);
        memCnt = 3;
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic stall, input logic redirect, input logic [31:0] rpc);
    STALL = stall;
    REDIRECT = redirect;
    REDIRECT_PC = rpc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic waitValid(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles && INST_VALID !== 1'b1; i++) tick();
    checkOutput({tag, "_valid"}, 32'(INST_VALID), 32'd1);
  endtask

  // Directed sequence.
  initial begin
    vectors = 0;
    miscompares = 0;
    sawReadLow = 1'b0;
    RESET = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    #2;
    checkOutput("rst_instr", INSTRUCTION, 32'h0);
    checkOutput("rst_pc", INST_PC, 32'h0);
    checkOutput("rst_valid", 32'(INST_VALID), 32'd0);
    checkOutput("rst_read", 32'(MEM_READ), 32'd0);
    checkOutput("rst_addr", 32'(MEM_ADDRESS), 32'd0);
    checkOutput("rst_cnt", 32'(MISS_COUNT), 32'd0);
    tick(); tick();
    RESET = 1'b0;

    // Cold miss on line 0, then sequential hits
    tick();
    checkOutput("miss0_read", 32'(MEM_READ), 32'd1);
    checkOutput("miss0_addr", 32'(MEM_ADDRESS), 32'd0);
    checkOutput("miss0_cnt", 32'(MISS_COUNT), 32'd1);
    checkOutput("miss0_valid", 32'(INST_VALID), 32'd0);
    waitValid("fill0", 20);
    checkOutput("hit0_instr", INSTRUCTION, 32'h1);
    checkOutput("hit0_pc", INST_PC, 32'h0);
    checkOutput("hit0_read", 32'(MEM_READ), 32'd0);
    tick();
    checkOutput("hit1_instr", INSTRUCTION, 32'h2);
    checkOutput("hit1_pc", INST_PC, 32'h4);

    // Stall holds instruction 2 for three cycles
    applyStimulus(1'b1, 1'b0, 32'h0);
    tick();
    checkOutput("stall1_instr", INSTRUCTION, 32'h2);
    checkOutput("stall1_pc", INST_PC, 32'h4);
    tick();
    checkOutput("stall2_instr", INSTRUCTION, 32'h2);
    checkOutput("stall2_pc", INST_PC, 32'h4);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("hit2_instr", INSTRUCTION, 32'h3);
    checkOutput("hit2_pc", INST_PC, 32'h8);
    tick();
    checkOutput("hit3_instr", INSTRUCTION, 32'h4);
    checkOutput("hit3_pc", INST_PC, 32'hC);
    checkOutput("hit3_cnt", 32'(MISS_COUNT), 32'd1);

    // Redirect inside the buffered line: low bits ignored, no memory read
    applyStimulus(1'b0, 1'b1, 32'h0000_000B);
    tick();
    checkOutput("redir8_valid", 32'(INST_VALID), 32'd0);
    checkOutput("redir8_read", 32'(MEM_READ), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("redir8_instr", INSTRUCTION, 32'h3);
    checkOutput("redir8_pc", INST_PC, 32'h8);
    checkOutput("redir8_noread", 32'(MEM_READ), 32'd0);
    tick();
    checkOutput("redirC_pc", INST_PC, 32'hC);

    // Miss on line 1, redirect to 0x46 while waiting
    tick();
    checkOutput("miss1_read", 32'(MEM_READ), 32'd1);
    checkOutput("miss1_addr", 32'(MEM_ADDRESS), 32'd1);
    checkOutput("miss1_cnt", 32'(MISS_COUNT), 32'd2);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h0000_0046);
    tick();
    checkOutput("redir46_valid", 32'(INST_VALID), 32'd0);
    checkOutput("redir46_read", 32'(MEM_READ), 32'd1);
    checkOutput("redir46_addr", 32'(MEM_ADDRESS), 32'd1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 20 && !(MEM_READ === 1'b1 && MEM_ADDRESS === 6'd4); i++) begin
      tick();
      if (MEM_READ === 1'b0) sawReadLow = 1'b1;
    end
    checkOutput("miss4_addr", 32'(MEM_ADDRESS), 32'd4);
    checkOutput("fill1_done", 32'(sawReadLow), 32'd1);
    checkOutput("miss4_cnt", 32'(MISS_COUNT), 32'd3);
    waitValid("fill4", 20);
    checkOutput("hit44_pc", INST_PC, 32'h44);
    checkOutput("hit44_instr", INSTRUCTION, 32'h12);
    tick();
    checkOutput("hit48_instr", INSTRUCTION, 32'h13);
    tick();
    checkOutput("hit4C_pc", INST_PC, 32'h4C);

    // Miss on line 5 saturates the counter, then reset lands in MISS_WAIT
    tick();
    checkOutput("miss5_addr", 32'(MEM_ADDRESS), 32'd5);
    checkOutput("miss5_sat", 32'(MISS_COUNT), 32'd3);
    tick();
    RESET = 1'b1;
    #1;
    checkOutput("midrst_instr", INSTRUCTION, 32'h0);
    checkOutput("midrst_pc", INST_PC, 32'h0);
    checkOutput("midrst_valid", 32'(INST_VALID), 32'd0);
    checkOutput("midrst_read", 32'(MEM_READ), 32'd0);
    checkOutput("midrst_addr", 32'(MEM_ADDRESS), 32'd0);
    checkOutput("midrst_cnt", 32'(MISS_COUNT), 32'd0);
    tick();
    RESET = 1'b0;
    tick();
    checkOutput("postrst_read", 32'(MEM_READ), 32'd1);
    checkOutput("postrst_addr", 32'(MEM_ADDRESS), 32'd0);
    checkOutput("postrst_cnt", 32'(MISS_COUNT), 32'd1);
    checkOutput("postrst_valid", 32'(INST_VALID), 32'd0);
    waitValid("refill0", 20);
    checkOutput("refill0_instr", INSTRUCTION, 32'h1);
    checkOutput("refill0_pc", INST_PC, 32'h0);

    // 1 KiB alias: 0x3FC misses on line 63, 0x400 misses on line 0
    applyStimulus(1'b0, 1'b1, 32'h0000_03FC);
    tick();
    checkOutput("redir3FC_valid", 32'(INST_VALID), 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("miss3F_addr", 32'(MEM_ADDRESS), 32'd63);
    checkOutput("miss3F_cnt", 32'(MISS_COUNT), 32'd2);
    waitValid("fill3F", 20);
    checkOutput("hit3FC_pc", INST_PC, 32'h3FC);
    checkOutput("hit3FC_instr", INSTRUCTION, 32'h100);
    tick();
    checkOutput("alias_read", 32'(MEM_READ), 32'd1);
    checkOutput("alias_addr", 32'(MEM_ADDRESS), 32'd0);
    checkOutput("alias_cnt", 32'(MISS_COUNT), 32'd3);
    waitValid("fillAlias", 20);
    checkOutput("hit400_pc", INST_PC, 32'h400);
    checkOutput("hit400_instr", INSTRUCTION, 32'h1);

    // One more miss keeps the counter pinned at all-ones
    applyStimulus(1'b0, 1'b1, 32'h0000_0010);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0);
    tick();
    checkOutput("sat_addr", 32'(MEM_ADDRESS), 32'd1);
    checkOutput("sat_cnt", 32'(MISS_COUNT), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_controller.md
INSTRUCTION_FETCH_CONTROLLER -- requirements
Module: instruction_fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC loaded on reset.
REQ-002 Parameter MISS_CNT_W, default 16, width of the miss counter.
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 STALL  input  1  pipeline stall; hold the current output instruction.
REQ-006 REDIRECT  input  1  branch/jump redirect strobe.
REQ-007 REDIRECT_PC  input  32  redirect target; bits [1:0] ignored, treated as 00.
REQ-008 INSTRUCTION  output  32  fetched instruction (registered).
REQ-009 INST_PC  output  32  address of INSTRUCTION (registered).
REQ-010 INST_VALID  output  1  INSTRUCTION/INST_PC valid this cycle.
REQ-011 MEM_READ  output  1  line-read request to the 128-bit instruction memory.
REQ-012 MEM_ADDRESS  output  6  line address, equal to PC[9:4] of the missing line.
REQ-013 MEM_READINST  input  128  returned line; word k at bits [32k+31:32k].
REQ-014 MEM_BUSYWAIT  input  1  memory busy; high while a read is in progress.
REQ-015 MISS_COUNT  output  MISS_CNT_W  saturating count of line misses.

Function
REQ-016 Controller SHALL hold one 128-bit line buffer, a 6-bit tag and a valid bit; a hit is valid && tag == PC[9:4].
REQ-017 FSM states: FETCH, MISS_REQ, MISS_WAIT; encodings 2'b00, 2'b01, 2'b10.
REQ-018 FETCH, hit, STALL=0: next edge loads INSTRUCTION with word PC[3:2], INST_PC with PC, INST_VALID with 1, and PC with PC+4 (mod 2^32); one-cycle hit latency.
REQ-019 FETCH, STALL=1: INSTRUCTION, INST_PC, INST_VALID and PC SHALL hold.
REQ-020 FETCH, miss, STALL=0: next edge sets MEM_READ=1, MEM_ADDRESS=PC[9:4], increments MISS_COUNT (saturating at all-ones), clears INST_VALID, and enters MISS_REQ.
REQ-021 MISS_REQ: MEM_READ stays 1; on sampling MEM_BUSYWAIT=1, go to MISS_WAIT; if BUSYWAIT is never raised, remain in MISS_REQ.
REQ-022 MISS_WAIT, on the first edge with MEM_BUSYWAIT=0:
- capture MEM_READINST into the buffer;
- set the tag to MEM_ADDRESS and valid to 1;
- clear MEM_READ;
- return to FETCH.
REQ-023 MEM_READ SHALL not deassert and MEM_ADDRESS SHALL not change while in MISS_REQ or MISS_WAIT.
REQ-024 During MISS_REQ/MISS_WAIT, output registers hold if STALL=1; otherwise INST_VALID=0.
REQ-025 REDIRECT=1 in any state: next edge sets PC to {REDIRECT_PC[31:2],2'b00} and INST_VALID to 0, regardless of STALL (REDIRECT overrides STALL).
REQ-026 REDIRECT during MISS_REQ/MISS_WAIT SHALL NOT abort the memory transaction; the line is still filled, then the hit check applies to the new PC.
REQ-027 REDIRECT coinciding with the MISS_WAIT completion edge: fill and redirect both take effect on that edge.
REQ-028 A REDIRECT to a PC in the buffered line SHALL hit without a memory read.
REQ-029 PC bits [31:10] SHALL not participate in tag compare; aliasing every 1 KiB is intended.

Reset
REQ-030 While RESET=1, asynchronously:
- PC=RESET_PC, state=FETCH;
- buffer valid=0, tag=0, buffer=0;
- INSTRUCTION=0, INST_PC=0, INST_VALID=0;
- MEM_READ=0, MEM_ADDRESS=0, MISS_COUNT=0.
REQ-031 RESET mid-miss SHALL drop the transaction; any late BUSYWAIT fall after reset SHALL not fill the buffer.

Structure
REQ-032 Shared package SHALL hold the FSM state type/encodings, LINE_WORDS=4, LINE_ADDR_W=6 and the INST_W=32 constant.
REQ-033 The line buffer with tag compare and word select SHALL be a sub-module named fetch_line_buffer; the FSM, PC and counter stay in the top.

Verification
REQ-034 Reset, then a memory model with 3-cycle BUSYWAIT holding line 0 = {32'h4,32'h3,32'h2,32'h1} -> one miss (MEM_ADDRESS=0), then INSTRUCTION 1,2,3,4 on consecutive cycles with INST_PC 0,4,8,C; MISS_COUNT=1.
REQ-035 STALL=1 for 2 cycles after INSTRUCTION=2 -> INSTRUCTION=2 and INST_PC=4 held for 3 cycles, then 3 follows.
REQ-036 REDIRECT to 32'h0000_0046 while in MISS_WAIT for line 1 -> line 1 still filled, INST_VALID=0, next read MEM_ADDRESS=4, first valid INST_PC=32'h44.
REQ-037 REDIRECT to 32'h8 while executing line 0 -> no MEM_READ, next INST_PC=8.
REQ-038 RESET asserted while in MISS_WAIT -> all outputs 0 immediately, MEM_READ=0, buffer invalid, the next fetch misses at RESET_PC.
REQ-039 PC 32'h0000_03FC -> next fetch at 32'h400 misses on MEM_ADDRESS=0 (alias); force MISS_COUNT to all-ones -> it stays saturated.
